// File: rtl/pc_pkg.sv
// Shared types, default widths and offset sign-extension for the PC sequencer.
// The stack build is selected by the PC_STACK_EN macro in the top-level file.
package pc_pkg;

    localparam int PC_W_DEF        = 16;
    localparam int OFFS_W_DEF      = 8;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_INC,
        SRC_BR,
        SRC_JMP,
        SRC_CALL,
        SRC_RET
    } pc_src_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } seq_state_e;

    // Sign-extend the low offs_w bits of off to 64 bits; callers truncate to PC width.
    function automatic logic [63:0] sext_off(input logic [63:0] off, input int offs_w);
        logic [63:0] hi_mask;
        hi_mask = ~64'd0 << offs_w;
        if ((off & (64'd1 << (offs_w - 1))) != 64'd0) begin
            return off | hi_mask;
        end
        return off & ~hi_mask;
    endfunction

endpackage

// File: rtl/pc_stack_seq_if.sv
// Decoder-to-sequencer bundle: one-hot control strobes in, fetch address and status out.
// Strobes carry no handshake: each one is sampled on every rising edge and acts that cycle.
interface pc_stack_seq_if #(
    parameter int PC_W    = 16,
    parameter int OFFS_W  = 8,
    parameter int DEPTH_W = 3
);
    import pc_pkg::*;

    logic              init;
    logic              stall;
    logic              branch_en;
    logic [OFFS_W-1:0] branch_off;
    logic              jump_en;
    logic              call_en;
    logic              ret_en;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   PC;
    logic              halt;
    logic              fault;
    logic [DEPTH_W-1:0] depth;
    seq_state_e        state;

    modport master (
        output init, stall, branch_en, branch_off, jump_en, call_en, ret_en, target,
        input  PC, halt, fault, depth, state
    );

    modport slave (
        input  init, stall, branch_en, branch_off, jump_en, call_en, ret_en, target,
        output PC, halt, fault, depth, state
    );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: push stores din, pop discards the top, top is the most recent entry.
// clr empties the stack synchronously; pushing when full or popping when empty is ignored.
module pc_ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] depth
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign depth = cnt;
    assign top   = mem[IDX_W'(cnt - 1'b1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Entry storage needs no reset: contents are only read below the occupied count.
    always_ff @(posedge clk) begin
        if (!clr && push && !full) begin
            mem[IDX_W'(cnt)] <= din;
        end
    end

endmodule

// File: rtl/pc_stack_seq.sv
// Fetch-stage PC sequencer: increment, relative branch, jump, call/return, stall and halt.
// Define PC_STACK_EN to build the return stack; without it call acts as jump and ret is ignored.
module pc_stack_seq
    import pc_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter int              OFFS_W      = OFFS_W_DEF,
    parameter int              STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [PC_W-1:0] PC_MAX      = {PC_W{1'b1}}
) (
    input  logic         CLK,
    input  logic         RST_N,
    pc_stack_seq_if.slave bus
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    seq_state_e      state_q, state_d;
    pc_src_e         src;
    logic [PC_W-1:0] pc_q, pc_d, br_sum, ret_addr;
    logic            fault_q, fault_d;
    logic            push, pop, halt_set, fault_set;
    logic            ret_act, stk_full, stk_empty;
    logic [PC_W-1:0] stk_top;

    assign ret_addr = pc_q + 1'b1;
    assign br_sum   = PC_W'(64'(pc_q) + sext_off(64'(bus.branch_off), OFFS_W));

`ifdef PC_STACK_EN
    logic [DEPTH_W-1:0] stk_depth;

    assign ret_act = bus.ret_en;

    pc_ret_stack #(
        .WIDTH (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (bus.init),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .depth (stk_depth)
    );

    assign bus.depth = stk_depth;
`else
    logic unused_stk;

    // Never full and never consulted for ret, so a call degenerates to a plain jump.
    assign ret_act    = 1'b0;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
    assign stk_top    = '0;
    assign bus.depth  = DEPTH_W'(0);
    assign unused_stk = ^{push, pop, bus.ret_en, ret_addr};
`endif

    // Source select and halt/fault requests; init is applied on top of this below.
    always_comb begin
        src       = SRC_HOLD;
        push      = 1'b0;
        pop       = 1'b0;
        halt_set  = 1'b0;
        fault_set = 1'b0;
        if (state_q == ST_RUN && !bus.stall) begin
            if (ret_act) begin
                if (stk_empty) begin
                    halt_set  = 1'b1;
                    fault_set = 1'b1;
                end else begin
                    src = SRC_RET;
                    pop = 1'b1;
                end
            end else if (bus.call_en) begin
                if (stk_full) begin
                    halt_set  = 1'b1;
                    fault_set = 1'b1;
                end else begin
                    src  = SRC_CALL;
                    push = 1'b1;
                end
            end else if (bus.jump_en) begin
                src = SRC_JMP;
            end else if (bus.branch_en) begin
                src = SRC_BR;
            end else if (pc_q == PC_MAX) begin
                halt_set = 1'b1;
            end else begin
                src = SRC_INC;
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        fault_d = fault_q | fault_set;
        case (src)
            SRC_INC:           pc_d = ret_addr;
            SRC_BR:            pc_d = br_sum;
            SRC_JMP, SRC_CALL: pc_d = bus.target;
            SRC_RET:           pc_d = stk_top;
            default:           pc_d = pc_q;
        endcase
        if (halt_set) begin
            state_d = ST_HALT;
        end
        if (bus.init) begin
            pc_d    = RESET_PC;
            state_d = ST_RUN;
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign bus.PC    = pc_q;
    assign bus.halt  = (state_q == ST_HALT);
    assign bus.fault = fault_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Self-checking bench for pc_stack_seq with PC_MAX=20 and a 4-entry stack; works with or
// without PC_STACK_EN by switching the reference model's stack behaviour the same way.
module tb_pc_stack_seq;
    import pc_pkg::*;

    localparam int              PC_W     = 16;
    localparam int              OFFS_W   = 8;
    localparam int              SDEPTH   = 4;
    localparam int              DEPTH_W  = 3;
    localparam logic [PC_W-1:0] RST_PC   = 16'd0;
    localparam logic [PC_W-1:0] MAX_PC   = 16'd20;
    localparam int              W        = PC_W + 2 + DEPTH_W;
`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    logic [W-1:0]    exp_q[$];
    logic [PC_W-1:0] m_pc;
    logic            m_halt;
    logic            m_fault;
    int              m_depth;
    logic [PC_W-1:0] m_stack[SDEPTH];

    pc_stack_seq_if #(.PC_W(PC_W), .OFFS_W(OFFS_W), .DEPTH_W(DEPTH_W)) bus ();

    pc_stack_seq #(
        .PC_W        (PC_W),
        .OFFS_W      (OFFS_W),
        .STACK_DEPTH (SDEPTH),
        .RESET_PC    (RST_PC),
        .PC_MAX      (MAX_PC)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_halt  = 1'b0;
        m_fault = 1'b0;
        m_depth = 0;
    endtask

    // One cycle: drive strobes, advance the reference model, then compare after the edge.
    task automatic drive(input logic i_init, input logic i_stall, input logic i_br,
                         input logic [7:0] off, input logic i_jmp, input logic i_call,
                         input logic i_ret, input logic [15:0] tgt);
        logic [W-1:0] e;
        bus.init       = i_init;
        bus.stall      = i_stall;
        bus.branch_en  = i_br;
        bus.branch_off = off;
        bus.jump_en    = i_jmp;
        bus.call_en    = i_call;
        bus.ret_en     = i_ret;
        bus.target     = tgt;
        if (i_init) begin
            model_reset();
        end else if (!m_halt && !i_stall) begin
            if (STK && i_ret) begin
                if (m_depth == 0) begin
                    m_halt  = 1'b1;
                    m_fault = 1'b1;
                end else begin
                    m_depth = m_depth - 1;
                    m_pc    = m_stack[m_depth];
                end
            end else if (i_call) begin
                if (STK && m_depth == SDEPTH) begin
                    m_halt  = 1'b1;
                    m_fault = 1'b1;
                end else begin
                    if (STK) begin
                        m_stack[m_depth] = m_pc + 16'd1;
                        m_depth = m_depth + 1;
                    end
                    m_pc = tgt;
                end
            end else if (i_jmp) begin
                m_pc = tgt;
            end else if (i_br) begin
                m_pc = m_pc + {{8{off[7]}}, off};
            end else if (m_pc == MAX_PC) begin
                m_halt = 1'b1;
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
        exp_q.push_back({m_pc, m_halt, m_fault, 3'(m_depth)});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check("pc",    32'(bus.PC),    32'(e[W-1:5]));
        check("halt",  32'(bus.halt),  32'(e[4]));
        check("fault", 32'(bus.fault), 32'(e[3]));
        check("depth", 32'(bus.depth), 32'(e[2:0]));
        check("state", {31'b0, bus.state == ST_HALT}, 32'(e[4]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0, 0, 0, 16'h0);
    endtask
    task automatic do_jmp(input logic [15:0] t);  drive(0, 0, 0, 8'h00, 1, 0, 0, t); endtask
    task automatic do_call(input logic [15:0] t); drive(0, 0, 0, 8'h00, 0, 1, 0, t); endtask
    task automatic do_ret();                      drive(0, 0, 0, 8'h00, 0, 0, 1, 16'h0); endtask
    task automatic do_br(input logic [7:0] o);    drive(0, 0, 1, o, 0, 0, 0, 16'h0); endtask
    task automatic do_init();                     drive(1, 0, 0, 8'h00, 0, 0, 0, 16'h0); endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    32'(bus.PC),    32'(RST_PC));
        check({tag, "_halt"},  32'(bus.halt),  32'd0);
        check({tag, "_fault"}, 32'(bus.fault), 32'd0);
        check({tag, "_depth"}, 32'(bus.depth), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST_N    = 1'b0;
        bus.init = 1'b0; bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_off = '0;
        bus.jump_en = 1'b0; bus.call_en = 1'b0; bus.ret_en = 1'b0; bus.target = '0;
        model_reset();

        // Reset, release mid-cycle, then free-running increment.
        #12;
        check_reset_values("rst");
        #6;
        RST_N = 1'b1;
        #1;
        check("rel_pc", 32'(bus.PC), 32'(RST_PC));
        idle(5);
        check("inc5", 32'(bus.PC), 32'd5);

        // Relative branches, backwards and wrapping below zero.
        do_jmp(16'd10);
        do_br(8'hFD);
        check("br_back", 32'(bus.PC), 32'd7);
        do_jmp(16'd0);
        do_br(8'hFF);
        check("br_wrap", 32'(bus.PC), 32'hFFFF);
        idle(2);

        // Run off PC_MAX, confirm the freeze ignores strobes and stall, then init.
        do_jmp(16'd15);
        idle(6);
        check("max_halt", 32'(bus.halt), 32'd1);
        do_jmp(16'd3);
        do_call(16'd50);
        do_ret();
        do_br(8'h02);
        drive(0, 1, 0, 8'h00, 1, 0, 0, 16'd9);
        do_init();
        idle(2);

        // Call and return, then return from an empty stack.
        do_jmp(16'd5);
        do_call(16'd100);
        check("call_pc", 32'(bus.PC), 32'd100);
        do_ret();
        do_ret();
`ifdef PC_STACK_EN
        check("ret_pc", 32'(bus.PC), 32'd6);
        check("underflow", 32'({bus.halt, bus.fault}), 32'd3);
`endif
        do_init();

        // Nested calls up to overflow.
        do_call(16'd30);
        do_call(16'd40);
        do_call(16'd50);
        do_call(16'd60);
        do_call(16'd70);
`ifdef PC_STACK_EN
        check("overflow", 32'({bus.halt, bus.fault, bus.depth}), 32'h1C);
        check("overflow_pc", 32'(bus.PC), 32'd60);
`endif

        // Asynchronous reset while halted takes effect before the next edge.
        #3;
        RST_N = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        #1;

        // Stall beats jump; init beats call; call target 40.
        idle(2);
        drive(0, 1, 0, 8'h00, 1, 0, 0, 16'd12);
        check("stall_pc", 32'(bus.PC), 32'd2);
        do_call(16'd8);
        drive(1, 0, 0, 8'h00, 0, 1, 0, 16'd77);
        check("init_call", 32'({bus.PC, bus.depth}), 32'd0);
        do_call(16'd40);
        check("call40", 32'(bus.PC), 32'd40);

        // Random overlapping strobes against the reference model.
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, 16'($urandom_range(0, 30)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
